// File: rtl/mem_wait_bridge.sv
// mem_wait_bridge: turns a single-cycle core read/write request into a bus
// transaction that waits for slave ready, stalling the core meanwhile.
// Optional macro MEM_WAIT_BRIDGE_TIMEOUT_EN adds a WAIT watchdog that
// raises oCoreFault after TIMEOUT_CYCLES cycles without iBusReady.
module mem_wait_bridge #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic                    iCoreRead,
  input  logic                    iCoreWrite,
  input  logic [ADDR_WIDTH-1:0]   iCoreAddress,
  input  logic [DATA_WIDTH-1:0]   iCoreWriteData,
  input  logic [DATA_WIDTH/8-1:0] iCoreByteEnable,
  output logic [DATA_WIDTH-1:0]   oCoreReadData,
  output logic                    oCoreStall,
  output logic                    oCoreDone,
  output logic                    oCoreFault,
  output logic                    oBusReadEnable,
  output logic                    oBusWriteEnable,
  output logic [ADDR_WIDTH-1:0]   oBusAddress,
  output logic [DATA_WIDTH-1:0]   oBusWriteData,
  output logic [DATA_WIDTH/8-1:0] oBusByteEnable,
  input  logic                    iBusReady,
  input  logic [DATA_WIDTH-1:0]   iBusReadData
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  // Elaboration-time parameter legality checks
  if ((DATA_WIDTH < 8) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_data_width
    $error("mem_wait_bridge: DATA_WIDTH must be a multiple of 8 and >= 8");
  end
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("mem_wait_bridge: TIMEOUT_CYCLES must be 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [BE_WIDTH-1:0]     be_q, be_d;
  logic                    wr_q, wr_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

`ifdef MEM_WAIT_BRIDGE_TIMEOUT_EN
  // Sized so the counter can hold TIMEOUT_CYCLES itself without wrapping
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // State, latched request and captured read data registers
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
`ifdef MEM_WAIT_BRIDGE_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
`ifdef MEM_WAIT_BRIDGE_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state: accept a request in IDLE, wait for ready, then pulse done/fault
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
`ifdef MEM_WAIT_BRIDGE_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (iCoreRead && iCoreWrite) begin
          state_d = S_FAULT;
        end else if (iCoreRead || iCoreWrite) begin
          addr_d  = iCoreAddress;
          wdata_d = iCoreWriteData;
          be_d    = iCoreByteEnable;
          wr_d    = iCoreWrite;
          state_d = S_WAIT;
`ifdef MEM_WAIT_BRIDGE_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_WAIT: begin
        if (iBusReady) begin
          if (!wr_q) rdata_d = iBusReadData;
          state_d = S_DONE;
        end else begin
`ifdef MEM_WAIT_BRIDGE_TIMEOUT_EN
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) state_d = S_FAULT;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes and pulses decode from state; forced low while reset is held
  assign oBusReadEnable  = !iRST && (state_q == S_WAIT) && !wr_q;
  assign oBusWriteEnable = !iRST && (state_q == S_WAIT) &&  wr_q;
  assign oCoreDone       = !iRST && (state_q == S_DONE);
  assign oCoreFault      = !iRST && (state_q == S_FAULT);
  assign oCoreStall      = (state_q == S_WAIT) ||
                           ((state_q == S_IDLE) && (iCoreRead || iCoreWrite));

  // Bus payload always comes from the latched request, never the live core bus
  assign oBusAddress    = addr_q;
  assign oBusWriteData  = wdata_q;
  assign oBusByteEnable = be_q;
  assign oCoreReadData  = rdata_q;

endmodule

// File: tb/tb_mem_wait_bridge.sv
// Directed testbench for mem_wait_bridge (DATA_WIDTH=32, TIMEOUT_CYCLES=4).
module tb_mem_wait_bridge;

  logic        clk;
  logic        rst;
  logic        core_rd;
  logic        core_wr;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [3:0]  core_be;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        core_done;
  logic        core_fault;
  logic        bus_re;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int n_pass;
  int n_total;

  mem_wait_bridge #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .iCLK(clk),
    .iRST(rst),
    .iCoreRead(core_rd),
    .iCoreWrite(core_wr),
    .iCoreAddress(core_addr),
    .iCoreWriteData(core_wdata),
    .iCoreByteEnable(core_be),
    .oCoreReadData(core_rdata),
    .oCoreStall(core_stall),
    .oCoreDone(core_done),
    .oCoreFault(core_fault),
    .oBusReadEnable(bus_re),
    .oBusWriteEnable(bus_we),
    .oBusAddress(bus_addr),
    .oBusWriteData(bus_wdata),
    .oBusByteEnable(bus_be),
    .iBusReady(bus_ready),
    .iBusReadData(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; core_rd = 1'b0; core_wr = 1'b0; core_addr = '0;
    core_wdata = '0; core_be = '0; bus_ready = 1'b0; bus_rdata = '0;
    step(); step();
    n_total++; if ({bus_re, bus_we} !== 2'b00) $display("FAIL rst_strobes: got %b exp 00", {bus_re, bus_we}); else n_pass++;
    n_total++; if ({core_done, core_fault} !== 2'b00) $display("FAIL rst_pulses: got %b exp 00", {core_done, core_fault}); else n_pass++;
    rst = 1'b0;
    step();
    n_total++; if (core_rdata !== 32'h0) $display("FAIL rst_rdata: got %h exp 00000000", core_rdata); else n_pass++;
    n_total++; if ({core_stall, bus_re, bus_we, core_done, core_fault} !== 5'b0) $display("FAIL rst_idle_outs: got %b exp 00000", {core_stall, bus_re, bus_we, core_done, core_fault}); else n_pass++;
  endtask

  // Read 0x1000, ready in first WAIT cycle, data DEADBEEF
  task automatic test_read_zero_wait();
    core_rd = 1'b1; core_addr = 32'h0000_1000;
    #1;
    n_total++; if (core_stall !== 1'b1) $display("FAIL rd_req_stall: got %b exp 1", core_stall); else n_pass++;
    step();
    core_rd = 1'b0; core_addr = 32'hFFFF_FFFF;
    bus_ready = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    #1;
    n_total++; if ({bus_re, bus_we} !== 2'b10) $display("FAIL rd_wait_strobes: got %b exp 10", {bus_re, bus_we}); else n_pass++;
    n_total++; if (bus_addr !== 32'h0000_1000) $display("FAIL rd_wait_addr: got %h exp 00001000", bus_addr); else n_pass++;
    n_total++; if ({core_stall, core_done} !== 2'b10) $display("FAIL rd_wait_stall_done: got %b exp 10", {core_stall, core_done}); else n_pass++;
    step();
    bus_ready = 1'b0; bus_rdata = 32'h0;
    n_total++; if (core_done !== 1'b1) $display("FAIL rd_done_latency: got %b exp 1", core_done); else n_pass++;
    n_total++; if (core_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_data: got %h exp deadbeef", core_rdata); else n_pass++;
    n_total++; if ({bus_re, bus_we, core_stall} !== 3'b000) $display("FAIL rd_done_outs: got %b exp 000", {bus_re, bus_we, core_stall}); else n_pass++;
    step();
    n_total++; if (core_done !== 1'b0) $display("FAIL rd_done_one_cycle: got %b exp 0", core_done); else n_pass++;
  endtask

  // Write 0x2004, ready after 3 WAIT cycles; a read request mid-WAIT is ignored
  task automatic test_write_wait();
    int strobe_cycles;
    strobe_cycles = 0;
    core_wr = 1'b1; core_addr = 32'h0000_2004; core_wdata = 32'h1234_5678; core_be = 4'b0011;
    step();
    core_wr = 1'b0; core_addr = '0; core_wdata = '0; core_be = '0;
    for (int c = 0; c < 4; c++) begin
      core_rd = (c == 1);
      bus_ready = (c == 3);
      bus_rdata = 32'hBADB_AD00;
      #1;
      if (bus_we === 1'b1 && bus_re === 1'b0 && bus_be === 4'b0011 &&
          bus_wdata === 32'h1234_5678 && bus_addr === 32'h0000_2004) strobe_cycles++;
      n_total++; if (core_done !== 1'b0) $display("FAIL wr_early_done: cycle %0d got %b exp 0", c, core_done); else n_pass++;
      step();
    end
    core_rd = 1'b0; bus_ready = 1'b0;
    n_total++; if (strobe_cycles !== 4) $display("FAIL wr_strobe_cycles: got %0d exp 4", strobe_cycles); else n_pass++;
    n_total++; if ({core_done, bus_we, bus_re} !== 3'b100) $display("FAIL wr_done: got %b exp 100", {core_done, bus_we, bus_re}); else n_pass++;
    n_total++; if (core_rdata !== 32'hDEAD_BEEF) $display("FAIL wr_rdata_kept: got %h exp deadbeef", core_rdata); else n_pass++;
    step();
    n_total++; if ({core_done, bus_re, bus_we} !== 3'b000) $display("FAIL wr_after_done: got %b exp 000", {core_done, bus_re, bus_we}); else n_pass++;
    // Ready while idle must not capture data nor complete anything
    bus_ready = 1'b1; bus_rdata = 32'h0BAD_0BAD;
    step();
    bus_ready = 1'b0;
    n_total++; if (core_rdata !== 32'hDEAD_BEEF) $display("FAIL idle_ready_rdata: got %h exp deadbeef", core_rdata); else n_pass++;
    n_total++; if ({core_done, core_fault} !== 2'b00) $display("FAIL idle_ready_pulses: got %b exp 00", {core_done, core_fault}); else n_pass++;
  endtask

  task automatic test_dual_request();
    core_rd = 1'b1; core_wr = 1'b1; core_addr = 32'h0000_4000;
    #1;
    n_total++; if (core_stall !== 1'b1) $display("FAIL dual_stall: got %b exp 1", core_stall); else n_pass++;
    step();
    core_rd = 1'b0; core_wr = 1'b0;
    #1;
    n_total++; if ({core_fault, bus_re, bus_we, core_stall} !== 4'b1000) $display("FAIL dual_fault: got %b exp 1000", {core_fault, bus_re, bus_we, core_stall}); else n_pass++;
    n_total++; if (bus_addr !== 32'h0000_2004) $display("FAIL dual_no_latch: got %h exp 00002004", bus_addr); else n_pass++;
    step();
    n_total++; if ({core_fault, core_done} !== 2'b00) $display("FAIL dual_fault_one_cycle: got %b exp 00", {core_fault, core_done}); else n_pass++;
  endtask

  // Read with a slave that does not answer
  task automatic test_timeout();
    int strobe_cycles;
    strobe_cycles = 0;
    core_rd = 1'b1; core_addr = 32'h0000_5000;
    step();
    core_rd = 1'b0;
`ifdef MEM_WAIT_BRIDGE_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      if (bus_re === 1'b1 && core_fault === 1'b0) strobe_cycles++;
      step();
    end
    n_total++; if (strobe_cycles !== 4) $display("FAIL to_wait_cycles: got %0d exp 4", strobe_cycles); else n_pass++;
    n_total++; if ({core_fault, core_done, bus_re} !== 3'b100) $display("FAIL to_fault: got %b exp 100", {core_fault, core_done, bus_re}); else n_pass++;
    n_total++; if (core_rdata !== 32'hDEAD_BEEF) $display("FAIL to_rdata_kept: got %h exp deadbeef", core_rdata); else n_pass++;
    step();
    n_total++; if ({core_fault, core_done, bus_re, core_stall} !== 4'b0000) $display("FAIL to_back_idle: got %b exp 0000", {core_fault, core_done, bus_re, core_stall}); else n_pass++;
`else
    for (int c = 0; c < 12; c++) begin
      if (bus_re === 1'b1 && core_fault === 1'b0 && core_done === 1'b0) strobe_cycles++;
      step();
    end
    n_total++; if (strobe_cycles !== 12) $display("FAIL nto_wait_persist: got %0d exp 12", strobe_cycles); else n_pass++;
    bus_ready = 1'b1; bus_rdata = 32'hCAFE_F00D;
    step();
    bus_ready = 1'b0; bus_rdata = '0;
    n_total++; if ({core_done, core_fault} !== 2'b10) $display("FAIL nto_done: got %b exp 10", {core_done, core_fault}); else n_pass++;
    n_total++; if (core_rdata !== 32'hCAFE_F00D) $display("FAIL nto_rdata: got %h exp cafef00d", core_rdata); else n_pass++;
    step();
    n_total++; if ({core_fault, core_done, bus_re} !== 3'b000) $display("FAIL nto_back_idle: got %b exp 000", {core_fault, core_done, bus_re}); else n_pass++;
`endif
  endtask

  // Reset asserted in the 2nd WAIT cycle of a read
  task automatic test_reset_mid_wait();
    core_rd = 1'b1; core_addr = 32'h0000_3000;
    step();
    core_rd = 1'b0;
    step();
    n_total++; if (bus_re !== 1'b1) $display("FAIL rmw_in_wait: got %b exp 1", bus_re); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if ({bus_re, bus_we, core_done, core_fault} !== 4'b0000) $display("FAIL rmw_during_rst: got %b exp 0000", {bus_re, bus_we, core_done, core_fault}); else n_pass++;
    step();
    rst = 1'b0;
    bus_ready = 1'b1; bus_rdata = 32'h7777_7777;
    #1;
    n_total++; if ({bus_re, bus_we, core_done, core_fault, core_stall} !== 5'b00000) $display("FAIL rmw_after_rst: got %b exp 00000", {bus_re, bus_we, core_done, core_fault, core_stall}); else n_pass++;
    n_total++; if (core_rdata !== 32'h0) $display("FAIL rmw_rdata: got %h exp 00000000", core_rdata); else n_pass++;
    n_total++; if (bus_addr !== 32'h0) $display("FAIL rmw_addr_clr: got %h exp 00000000", bus_addr); else n_pass++;
    step();
    bus_ready = 1'b0;
    n_total++; if ({core_done, core_fault, core_rdata} !== {2'b00, 32'h0}) $display("FAIL rmw_no_pulse: got %b/%h exp 00/00000000", {core_done, core_fault}, core_rdata); else n_pass++;
  endtask

  // Two reads issued back to back from IDLE
  task automatic test_back_to_back();
    for (int k = 0; k < 2; k++) begin
      core_rd = 1'b1; core_addr = 32'h0000_6000 + 32'(k * 4);
      step();
      core_rd = 1'b0;
      bus_ready = 1'b1; bus_rdata = (k == 0) ? 32'hA5A5_0001 : 32'h5A5A_0002;
      #1;
      n_total++; if (bus_addr !== 32'h0000_6000 + 32'(k * 4)) $display("FAIL b2b_addr%0d: got %h", k, bus_addr); else n_pass++;
      step();
      bus_ready = 1'b0;
      n_total++; if (core_done !== 1'b1 || core_rdata !== ((k == 0) ? 32'hA5A5_0001 : 32'h5A5A_0002)) $display("FAIL b2b_done%0d: done %b data %h", k, core_done, core_rdata); else n_pass++;
      step();
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_dual_request();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
